// File: rtl/channel_fifo.sv
// First-word-fall-through channel FIFO on a circular buffer, one-cycle write-to-read latency.
// All handshake and status outputs are registered; out_data is a registered copy of the head entry.
module channel_fifo #(
    parameter int unsigned DWIDTH      = 16,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DWIDTH-1:0]            in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DWIDTH-1:0]            out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         almost_full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr_nxt;
    logic [PW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     count_nxt;
    logic [DWIDTH-1:0] head_nxt;
    logic              push;
    logic              pop;

    // Handshakes, pointer/occupancy updates and the head word visible after this edge.
    always_comb begin
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (push) begin
            wr_ptr_nxt = wr_ptr + PW'(1);
        end
        if (pop) begin
            rd_ptr_nxt = rd_ptr + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        // The new head is the incoming word only when the buffer drains to empty this edge.
        head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? in_data : mem[rd_ptr_nxt];
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
            out_data    <= '0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            in_ready    <= (count_nxt != CW'(DEPTH));
            out_valid   <= (count_nxt != '0);
            almost_full <= (32'(count_nxt) >= AFULL_LEVEL);
            out_data    <= head_nxt;
        end
    end

    // Payload storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_channel_fifo.sv
// Scoreboard bench for channel_fifo: a queue model tracks accepted words, a monitor checks
// status and head data every cycle, and popped words are compared in order.
module tb_channel_fifo;

    localparam int unsigned DWIDTH = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AFULL  = DEPTH - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DWIDTH-1:0] out_data;
    logic              out_ready;
    logic [2:0]        count;
    logic              almost_full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DWIDTH-1:0] exp_q[$];
    bit                armed = 1'b0;

    channel_fifo #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset empties the model and the FIFO stays closed until the first edge after release.
    always @(negedge rst) begin
        exp_q.delete();
        armed = 1'b0;
    end

    // Scoreboard: pop-and-compare on each handshake, then record accepted words.
    always @(posedge clk) begin
        if (rst) begin
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
            armed = 1'b1;
        end
    end

    // Status monitor sampled mid-cycle.
    always @(negedge clk) begin
        check("count", 32'(count), 32'(exp_q.size()));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(armed && (exp_q.size() != DEPTH)));
        check("almost_full", 32'(almost_full), 32'(exp_q.size() >= AFULL));
        if (exp_q.size() > 0) begin
            check("head_data", 32'(out_data), 32'(exp_q[0]));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset and idle
        repeat (2) cyc();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        rst = 1'b1;
        cyc();
        check("idle_in_ready", 32'(in_ready), 32'h1);
        check("idle_count", 32'(count), 32'h0);

        // Single pass
        in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("single_valid", 32'(out_valid), 32'h1);
        check("single_data", 32'(out_data), 32'hBEEF);
        cyc();
        check("single_drained", 32'(out_valid), 32'h0);
        check("single_count", 32'(count), 32'h0);

        // Fill and backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = DWIDTH'(i);
            cyc();
        end
        in_data = 16'h0005;
        repeat (2) cyc();
        check("full_count", 32'(count), 32'h4);
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_afull", 32'(almost_full), 32'h1);
        check("full_head", 32'(out_data), 32'h0001);

        // Full with simultaneous push request and pop
        out_ready = 1'b1;
        cyc();
        check("full_pop_only", 32'(count), 32'h3);
        check("full_pop_ready", 32'(in_ready), 32'h1);
        cyc();
        in_valid = 1'b0;
        check("full_push_pop", 32'(count), 32'h3);
        check("full_order", 32'(out_data), 32'h0003);
        repeat (4) cyc();
        check("full_drained", 32'(count), 32'h0);

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = 16'hA000 + DWIDTH'(i);
            cyc();
            check("wrap_count_le1", 32'(count <= 3'd1), 32'h1);
        end
        in_valid = 1'b0;
        repeat (2) cyc();
        check("wrap_drained", 32'(count), 32'h0);

        // Reset mid-stream
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = 16'hD000 + DWIDTH'(i);
            cyc();
        end
        in_valid = 1'b0;
        check("mid_count", 32'(count), 32'h3);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_count", 32'(count), 32'h0);
        #1 rst = 1'b1;
        cyc();
        in_valid = 1'b1; in_data = 16'hC0DE;
        cyc();
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_data", 32'(out_data), 32'hC0DE);
        out_ready = 1'b1;
        cyc();

        // Randomized traffic with occasional reset pulses
        for (int n = 0; n < 1500; n++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            in_data   = DWIDTH'($urandom);
            out_ready = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end
            cyc();
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) cyc();
        check("final_empty", 32'(count), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
